// File: rtl/ghash_stage4_accum.sv
// ---------------------------------------------------------------------------
// ghash_stage4_accum
//
// Final GHASH pipeline stage. Each valid beat XORs the reduced product from
// stage 3 with the aligned feedback (or with zero on the first beat of a
// message). The result becomes the running hash state, which is returned
// upstream as the next feedback. On the last beat the result becomes the tag.
// A two-state framing FSM (IDLE / ACCUM) tracks sop/eop and flags framing
// errors.
//
// Optional feature macro: GHASH_STAGE4_BEAT_CNT_EN
//   Defined   -> o_beat_cnt is present and counts accepted beats per message.
//   Undefined -> o_beat_cnt and the counter logic are absent.
//
// Ports
//   i_clock        clock, rising edge
//   i_reset        synchronous active-high reset
//   i_mod_prod     reduced product from stage 3
//   i_feedback     aligned hash feedback from stage 3
//   i_valid        qualifies i_mod_prod / i_feedback / i_sop / i_eop
//   i_sop          first beat of a message
//   i_eop          last beat of a message
//   o_hash_state   running hash (feedback path to stages 1/2)
//   o_ghash        final tag, held until the next tag
//   o_ghash_valid  one-cycle pulse when o_ghash is updated
//   o_busy         high while a message is open (FSM in ACCUM)
//   o_beat_cnt     accepted beats in current/last message (macro-gated)
//   o_err_framing  one-cycle pulse on a framing violation
// ---------------------------------------------------------------------------
module ghash_stage4_accum #(
    parameter int unsigned NB_BLOCK = 128,
    parameter int unsigned N_BLOCKS = 2,
    parameter int unsigned NB_DATA  = N_BLOCKS * NB_BLOCK,
    parameter int unsigned NB_CNT   = 32
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic [NB_BLOCK-1:0] i_mod_prod,
    input  logic [NB_BLOCK-1:0] i_feedback,
    input  logic                i_valid,
    input  logic                i_sop,
    input  logic                i_eop,
    output logic [NB_BLOCK-1:0] o_hash_state,
    output logic [NB_BLOCK-1:0] o_ghash,
    output logic                o_ghash_valid,
    output logic                o_busy,
`ifdef GHASH_STAGE4_BEAT_CNT_EN
    output logic [NB_CNT-1:0]   o_beat_cnt,
`endif
    output logic                o_err_framing
);

    // NB_DATA only sizes the upstream datapath; it is checked here so that a
    // mismatched instance is caught at elaboration.
    if (NB_DATA != N_BLOCKS * NB_BLOCK || NB_CNT == 0) begin : g_param_check
        $error("ghash_stage4_accum: inconsistent NB_DATA or zero NB_CNT");
    end

    typedef enum logic [0:0] {
        StIdle,
        StAccum
    } fsm_e;

    fsm_e                fsm_q, fsm_d;
    logic [NB_BLOCK-1:0] state_q, state_d;
    logic [NB_BLOCK-1:0] ghash_q, ghash_d;
    logic                ghash_valid_q, ghash_valid_d;
    logic                err_q, err_d;

    // Beat result: the first beat of a message ignores the feedback.
    logic [NB_BLOCK-1:0] beat_r;
    // Beat is part of a message (sop starts one, or a message is open).
    logic                beat_accepted;

    assign beat_r        = i_mod_prod ^ (i_sop ? '0 : i_feedback);
    assign beat_accepted = i_valid && (i_sop || (fsm_q == StAccum));

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            fsm_q         <= StIdle;
            state_q       <= '0;
            ghash_q       <= '0;
            ghash_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            fsm_q         <= fsm_d;
            state_q       <= state_d;
            ghash_q       <= ghash_d;
            ghash_valid_q <= ghash_valid_d;
            err_q         <= err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        fsm_d         = fsm_q;
        state_d       = state_q;
        ghash_d       = ghash_q;
        ghash_valid_d = 1'b0;
        err_d         = 1'b0;

        if (i_valid) begin
            if (i_sop) begin
                // A sop while a message is open abandons it without a tag;
                // the beat then starts a fresh message exactly as from IDLE.
                err_d = (fsm_q == StAccum);
                if (i_eop) begin
                    ghash_d       = beat_r;
                    ghash_valid_d = 1'b1;
                    state_d       = '0;
                    fsm_d         = StIdle;
                end else begin
                    state_d = beat_r;
                    fsm_d   = StAccum;
                end
            end else begin
                unique case (fsm_q)
                    StIdle: begin
                        // Continuation beat with no open message: drop it.
                        err_d = 1'b1;
                    end
                    StAccum: begin
                        if (i_eop) begin
                            ghash_d       = beat_r;
                            ghash_valid_d = 1'b1;
                            state_d       = '0;
                            fsm_d         = StIdle;
                        end else begin
                            state_d = beat_r;
                        end
                    end
                    default: begin
                        fsm_d = StIdle;
                    end
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        o_hash_state  = state_q;
        o_ghash       = ghash_q;
        o_ghash_valid = ghash_valid_q;
        o_err_framing = err_q;
        o_busy        = (fsm_q == StAccum);
    end

`ifdef GHASH_STAGE4_BEAT_CNT_EN
    // -----------------------------------------------------------------------
    // Beat counter: restarts at 1 on each accepted sop, saturates at all-ones,
    // holds after eop and ignores dropped beats.
    // -----------------------------------------------------------------------
    logic [NB_CNT-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (beat_accepted) begin
            if (i_sop) begin
                cnt_d = NB_CNT'(1);
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + NB_CNT'(1);
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_beat_cnt = cnt_q;
`else
    // Without the counter the acceptance decode has no consumer.
    logic unused_beat_accepted;
    assign unused_beat_accepted = beat_accepted;
`endif

endmodule

// File: tb/tb_ghash_stage4_accum.sv
module tb_ghash_stage4_accum;

    localparam int unsigned NB_BLOCK = 128;
    localparam int unsigned NB_CNT   = 32;

    logic                i_clock = 1'b0;
    logic                i_reset = 1'b1;
    logic [NB_BLOCK-1:0] i_mod_prod = '0;
    logic [NB_BLOCK-1:0] i_feedback = '0;
    logic                i_valid = 1'b0;
    logic                i_sop = 1'b0;
    logic                i_eop = 1'b0;
    logic [NB_BLOCK-1:0] o_hash_state;
    logic [NB_BLOCK-1:0] o_ghash;
    logic                o_ghash_valid;
    logic                o_busy;
    logic                o_err_framing;
`ifdef GHASH_STAGE4_BEAT_CNT_EN
    logic [NB_CNT-1:0]   o_beat_cnt;
`endif

    ghash_stage4_accum #(
        .NB_BLOCK (NB_BLOCK),
        .N_BLOCKS (2),
        .NB_DATA  (2 * NB_BLOCK),
        .NB_CNT   (NB_CNT)
    ) dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_mod_prod    (i_mod_prod),
        .i_feedback    (i_feedback),
        .i_valid       (i_valid),
        .i_sop         (i_sop),
        .i_eop         (i_eop),
        .o_hash_state  (o_hash_state),
        .o_ghash       (o_ghash),
        .o_ghash_valid (o_ghash_valid),
        .o_busy        (o_busy),
`ifdef GHASH_STAGE4_BEAT_CNT_EN
        .o_beat_cnt    (o_beat_cnt),
`endif
        .o_err_framing (o_err_framing)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        logic [NB_BLOCK-1:0] hs;
        logic [NB_BLOCK-1:0] tag;
        logic                tv;
        logic                busy;
        logic                err;
        logic [NB_CNT-1:0]   cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: a message is the list of its accepted beat results.
    logic [NB_BLOCK-1:0] msg[$];
    logic                m_open = 1'b0;
    logic [NB_BLOCK-1:0] m_tag  = '0;
    longint              m_cnt  = 0;

    task automatic chk(input string name, input logic [NB_BLOCK-1:0] act,
                       input logic [NB_BLOCK-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: one expectation per clock edge, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge i_clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("hash_state", o_hash_state, e.hs);
                chk("ghash", o_ghash, e.tag);
                chk("ghash_valid", {127'b0, o_ghash_valid}, {127'b0, e.tv});
                chk("busy", {127'b0, o_busy}, {127'b0, e.busy});
                chk("err_framing", {127'b0, o_err_framing}, {127'b0, e.err});
`ifdef GHASH_STAGE4_BEAT_CNT_EN
                chk("beat_cnt", {96'b0, o_beat_cnt}, {96'b0, e.cnt});
`endif
            end
        end
    end

    // Drive one cycle of inputs and push the model's prediction for it.
    task automatic drive(input logic rst, input logic v, input logic s, input logic e,
                         input logic [NB_BLOCK-1:0] mp, input logic [NB_BLOCK-1:0] fb);
        exp_t                x;
        logic [NB_BLOCK-1:0] r;
        logic                tv;
        logic                err;
        @(negedge i_clock);
        i_reset = rst; i_valid = v; i_sop = s; i_eop = e; i_mod_prod = mp; i_feedback = fb;
        tv  = 1'b0;
        err = 1'b0;
        if (rst) begin
            msg.delete();
            m_open = 1'b0;
            m_tag  = '0;
            m_cnt  = 0;
        end else if (v) begin
            r = s ? mp : (mp ^ fb);
            if (s) begin
                err = m_open;
                msg.delete();
                m_open = 1'b1;
            end else if (!m_open) begin
                err = 1'b1;
            end
            if (m_open) begin
                msg.push_back(r);
                m_cnt = (msg.size() > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : longint'(msg.size());
                if (e) begin
                    m_tag  = r;
                    tv     = 1'b1;
                    m_open = 1'b0;
                    msg.delete();
                end
            end
        end
        x.hs   = m_open ? msg[$] : '0;
        x.tag  = m_tag;
        x.tv   = tv;
        x.busy = m_open;
        x.err  = err;
        x.cnt  = NB_CNT'(m_cnt);
        exp_q.push_back(x);
    endtask

    task automatic beat(input logic s, input logic e, input logic [NB_BLOCK-1:0] mp,
                        input logic [NB_BLOCK-1:0] fb);
        drive(1'b0, 1'b1, s, e, mp, fb);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    function automatic logic [NB_BLOCK-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [NB_BLOCK-1:0] fb;
        // Reset for two cycles
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        idle(1);
        // Single-beat message
        beat(1'b1, 1'b1, 128'h5, 128'hF);
        idle(2);
        // Three-beat message with gaps
        beat(1'b1, 1'b0, 128'h1, 128'hFF);
        idle(1);
        beat(1'b0, 1'b0, 128'h2, 128'h10);
        idle(2);
        beat(1'b0, 1'b1, 128'h4, 128'h8);
        idle(1);
        // Continuation beat with no message open
        beat(1'b0, 1'b0, 128'hA, 128'h3);
        idle(1);
        // sop in the middle of a message
        beat(1'b1, 1'b0, 128'h1, 128'hFF);
        beat(1'b0, 1'b0, 128'h2, 128'h10);
        beat(1'b1, 1'b0, 128'h7, 128'h55);
        idle(1);
        // Reset while in ACCUM with a valid eop in the same cycle
        beat(1'b0, 1'b0, 128'h9, 128'h7);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 128'h3, 128'h1);
        idle(2);
        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            fb = ($urandom_range(0, 1) == 0) ? o_hash_state : rnd128();
            if ($urandom_range(0, 99) < 2)
                drive(1'b1, $urandom_range(0, 1) == 1, 1'b0, 1'b1, rnd128(), fb);
            else
                drive(1'b0, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 25,
                      $urandom_range(0, 99) < 30, rnd128(), fb);
        end
        idle(1);
        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge i_clock);
        #2;
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
